// File: rtl/sram_like_arbiter.sv
// Arbiter that lets the inst and data sram-like masters share one downstream bus, one transaction at a time.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise data has fixed priority over inst.
module sram_like_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              inst_req_i,
    input  logic              inst_wr_i,
    input  logic [1:0]        inst_size_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic [DATA_W-1:0] inst_wdata_i,
    output logic [DATA_W-1:0] inst_rdata_o,
    output logic              inst_addr_ok_o,
    output logic              inst_data_ok_o,
    input  logic              data_req_i,
    input  logic              data_wr_i,
    input  logic [1:0]        data_size_i,
    input  logic [ADDR_W-1:0] data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_addr_ok_o,
    output logic              data_data_ok_o,
    output logic              m_req_o,
    output logic              m_wr_o,
    output logic [1:0]        m_size_o,
    output logic [ADDR_W-1:0] m_addr_o,
    output logic [DATA_W-1:0] m_wdata_o,
    input  logic [DATA_W-1:0] m_rdata_i,
    input  logic              m_addr_ok_i,
    input  logic              m_data_ok_i
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    state_t            state_q, state_d;
    logic              owner_q, owner_d;
    logic              wr_q, wr_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              winner;
    logic              done;

    assign inst_rdata_o = m_rdata_i;
    assign data_rdata_o = m_rdata_i;

`ifdef ARB_RR_EN
    logic last_owner_q, last_owner_d;

    // On a tie the master that did not win last time goes first.
    always_comb begin
        winner = data_req_i;
        if (inst_req_i && data_req_i) begin
            winner = ~last_owner_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_owner_q <= 1'b0;
        end else begin
            last_owner_q <= last_owner_d;
        end
    end
`else
    always_comb begin
        winner = data_req_i;
    end
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            wr_q    <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        wr_d           = wr_q;
        size_d         = size_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
`ifdef ARB_RR_EN
        last_owner_d   = last_owner_q;
`endif
        done           = 1'b0;
        inst_addr_ok_o = 1'b0;
        data_addr_ok_o = 1'b0;
        m_req_o        = 1'b0;
        m_wr_o         = 1'b0;
        m_size_o       = '0;
        m_addr_o       = '0;
        m_wdata_o      = '0;

        case (state_q)
            IDLE: begin
                if (inst_req_i || data_req_i) begin
                    owner_d        = winner;
                    wr_d           = winner ? data_wr_i    : inst_wr_i;
                    size_d         = winner ? data_size_i  : inst_size_i;
                    addr_d         = winner ? data_addr_i  : inst_addr_i;
                    wdata_d        = winner ? data_wdata_i : inst_wdata_i;
                    inst_addr_ok_o = ~winner;
                    data_addr_ok_o = winner;
`ifdef ARB_RR_EN
                    last_owner_d   = winner;
`endif
                    state_d        = ADDR;
                end
            end
            ADDR: begin
                m_req_o   = 1'b1;
                m_wr_o    = wr_q;
                m_size_o  = size_q;
                m_addr_o  = addr_q;
                m_wdata_o = wdata_q;
                // A slave may accept and complete in the same cycle.
                if (m_addr_ok_i) begin
                    if (m_data_ok_i) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (m_data_ok_i) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        inst_data_ok_o = done & ~owner_q;
        data_data_ok_o = done & owner_q;

        // Reset silences every strobe immediately, even mid-transaction.
        if (rst_i) begin
            state_d        = IDLE;
            inst_addr_ok_o = 1'b0;
            data_addr_ok_o = 1'b0;
            inst_data_ok_o = 1'b0;
            data_data_ok_o = 1'b0;
            m_req_o        = 1'b0;
            m_wr_o         = 1'b0;
            m_size_o       = '0;
            m_addr_o       = '0;
            m_wdata_o      = '0;
        end
    end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed self-checking bench for sram_like_arbiter; tie expectations follow ARB_RR_EN.
module tb_sram_like_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        inst_req_i, inst_wr_i, data_req_i, data_wr_i;
    logic [1:0]  inst_size_i, data_size_i;
    logic [31:0] inst_addr_i, inst_wdata_i, data_addr_i, data_wdata_i;
    logic [31:0] inst_rdata_o, data_rdata_o;
    logic        inst_addr_ok_o, inst_data_ok_o, data_addr_ok_o, data_data_ok_o;
    logic        m_req_o, m_wr_o;
    logic [1:0]  m_size_o;
    logic [31:0] m_addr_o, m_wdata_o, m_rdata_i;
    logic        m_addr_ok_i, m_data_ok_i;

    int checks = 0;
    int failures = 0;

`ifdef ARB_RR_EN
    localparam logic RR = 1'b1;
`else
    localparam logic RR = 1'b0;
`endif

    sram_like_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .inst_req_i(inst_req_i), .inst_wr_i(inst_wr_i), .inst_size_i(inst_size_i),
        .inst_addr_i(inst_addr_i), .inst_wdata_i(inst_wdata_i), .inst_rdata_o(inst_rdata_o),
        .inst_addr_ok_o(inst_addr_ok_o), .inst_data_ok_o(inst_data_ok_o),
        .data_req_i(data_req_i), .data_wr_i(data_wr_i), .data_size_i(data_size_i),
        .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o),
        .data_addr_ok_o(data_addr_ok_o), .data_data_ok_o(data_data_ok_o),
        .m_req_o(m_req_o), .m_wr_o(m_wr_o), .m_size_o(m_size_o), .m_addr_o(m_addr_o),
        .m_wdata_o(m_wdata_o), .m_rdata_i(m_rdata_i), .m_addr_ok_i(m_addr_ok_i),
        .m_data_ok_i(m_data_ok_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic ireq, input logic dreq, input logic maok, input logic mdok);
        inst_req_i  = ireq;
        data_req_i  = dreq;
        m_addr_ok_i = maok;
        m_data_ok_i = mdok;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_i = 1'b1;
        inst_wr_i = 1'b0; inst_size_i = 2'd2; inst_addr_i = '0; inst_wdata_i = '0;
        data_wr_i = 1'b0; data_size_i = 2'd2; data_addr_i = '0; data_wdata_i = '0;
        m_rdata_i = '0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick();

        // Requests and slave strobes during reset must all be masked.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1);
        #1;
        checkOutput("rst_inst_aok", inst_addr_ok_o, 0);
        checkOutput("rst_data_aok", data_addr_ok_o, 0);
        checkOutput("rst_m_req", m_req_o, 0);
        checkOutput("rst_data_dok", data_data_ok_o, 0);
        checkOutput("rst_m_addr", m_addr_o, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        rst_i = 1'b0;
        tick();

        // Single fetch: grant, ADDR, DATA wait, completion.
        inst_addr_i = 32'hbfc00000;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("f_inst_aok", inst_addr_ok_o, 1);
        checkOutput("f_data_aok", data_addr_ok_o, 0);
        checkOutput("f_m_req0", m_req_o, 0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("f_m_req1", m_req_o, 1);
        checkOutput("f_m_addr", m_addr_o, 32'hbfc00000);
        checkOutput("f_m_size", m_size_o, 2);
        checkOutput("f_inst_aok1", inst_addr_ok_o, 0);
        checkOutput("f_inst_dok1", inst_data_ok_o, 0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("f_m_req2", m_req_o, 0);
        checkOutput("f_inst_dok2", inst_data_ok_o, 0);
        tick();
        m_rdata_i = 32'h3c080001;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("f_inst_dok3", inst_data_ok_o, 1);
        checkOutput("f_inst_rdata", inst_rdata_o, 32'h3c080001);
        checkOutput("f_data_dok3", data_data_ok_o, 0);
        checkOutput("f_data_aok3", data_addr_ok_o, 0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("f_idle_m_req", m_req_o, 0);
        checkOutput("f_idle_dok", inst_data_ok_o, 0);
        tick();

        // First tie after reset: data wins in both modes.
        data_addr_i = 32'h100;
        inst_addr_i = 32'h200;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("t1_data_aok", data_addr_ok_o, 1);
        checkOutput("t1_inst_aok", inst_addr_ok_o, 0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("t1_m_addr", m_addr_o, 32'h100);
        checkOutput("t1_data_dok", data_data_ok_o, 1);
        checkOutput("t1_inst_dok", inst_data_ok_o, 0);
        checkOutput("t1_inst_aok_busy", inst_addr_ok_o, 0);
        tick();

        // Second tie: round-robin picks inst, fixed priority picks data again.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("t2_inst_aok", inst_addr_ok_o, RR);
        checkOutput("t2_data_aok", data_addr_ok_o, !RR);
        tick();
        applyStimulus(!RR, RR, 1'b1, 1'b1);
        #1;
        checkOutput("t2_m_addr", m_addr_o, RR ? 32'h200 : 32'h100);
        checkOutput("t2_inst_dok", inst_data_ok_o, RR);
        checkOutput("t2_data_dok", data_data_ok_o, !RR);
        tick();
        applyStimulus(!RR, RR, 1'b0, 1'b0);
        #1;
        checkOutput("t2_loser_inst_aok", inst_addr_ok_o, !RR);
        checkOutput("t2_loser_data_aok", data_addr_ok_o, RR);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        #1;
        checkOutput("t2_loser_inst_dok", inst_data_ok_o, !RR);
        checkOutput("t2_loser_data_dok", data_data_ok_o, RR);
        tick();

        // Store with five cycles of back-pressure; latched command must not follow the inputs.
        data_wr_i = 1'b1; data_size_i = 2'd2;
        data_addr_i = 32'h80000010; data_wdata_i = 32'hdeadbeef;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("s_data_aok", data_addr_ok_o, 1);
        tick();
        data_wr_i = 1'b0; data_addr_i = '0; data_wdata_i = '0;
        inst_addr_i = 32'h300;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput($sformatf("bp%0d_m_req", i), m_req_o, 1);
            checkOutput($sformatf("bp%0d_m_wr", i), m_wr_o, 1);
            checkOutput($sformatf("bp%0d_m_size", i), m_size_o, 2);
            checkOutput($sformatf("bp%0d_m_addr", i), m_addr_o, 32'h80000010);
            checkOutput($sformatf("bp%0d_m_wdata", i), m_wdata_o, 32'hdeadbeef);
            checkOutput($sformatf("bp%0d_inst_aok", i), inst_addr_ok_o, 0);
            checkOutput($sformatf("bp%0d_data_aok", i), data_addr_ok_o, 0);
            tick();
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("s_accept_m_req", m_req_o, 1);
        checkOutput("s_accept_dok", data_data_ok_o, 0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("s_wait_dok", data_data_ok_o, 0);
        checkOutput("s_wait_inst_aok", inst_addr_ok_o, 0);
        tick();
        m_rdata_i = 32'h12345678;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("s_data_dok", data_data_ok_o, 1);
        checkOutput("s_data_rdata", data_rdata_o, 32'h12345678);
        checkOutput("s_inst_dok", inst_data_ok_o, 0);
        checkOutput("s_done_inst_aok", inst_addr_ok_o, 0);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("s_next_inst_aok", inst_addr_ok_o, 1);
        checkOutput("s_next_data_dok", data_data_ok_o, 0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checkOutput("r_m_addr", m_addr_o, 32'h300);
        tick();

        // Reset while waiting in DATA, then a stale data_ok right after release.
        rst_i = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("r_inst_dok", inst_data_ok_o, 0);
        checkOutput("r_data_dok", data_data_ok_o, 0);
        checkOutput("r_m_req", m_req_o, 0);
        tick();
        rst_i = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("stale_inst_dok", inst_data_ok_o, 0);
        checkOutput("stale_data_dok", data_data_ok_o, 0);
        checkOutput("stale_m_req", m_req_o, 0);
        tick();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("end_m_req", m_req_o, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
